gp_register_file: RTL and testbench

Parametrised general-purpose register bank replacing discrete 16-bit register/bus-buffer pairs in the datapath. Holds DEPTH registers of WIDTH bits, one synchronous write port from the data bus, an in-place increment/decrement port for program-counter and stack-pointer use, and two independently enabled three-state read ports driving the A and B buses. Sits between the data bus and the ALU operand buses; the control unit drives all selects and strobes.

---
 rtl/gp_regfile_pkg.sv | 11 +
 rtl/gp_register_cell.sv | 60 ++++++
 rtl/gp_register_file.sv | 106 ++++++++++
 tb/tb_gp_register_file.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gp_regfile_pkg.sv
// gp_regfile_pkg
//   Shared definitions for the general-purpose register bank: the encoding
//   of the two-bit count operation driven by the control unit.
package gp_regfile_pkg;

    localparam logic [1:0] OP_HOLD = 2'b00;  // leave the counted register alone
    localparam logic [1:0] OP_INC  = 2'b01;  // register[cntSel] + 1, wraps
    localparam logic [1:0] OP_DEC  = 2'b10;  // register[cntSel] - 1, wraps
    localparam logic [1:0] OP_RSVD = 2'b11;  // reserved, behaves as hold

endpackage

// File: rtl/gp_register_cell.sv
// gp_register_cell
//   One WIDTH-bit register of the bank. Load has priority over counting; the
//   caller keeps inc and dec mutually exclusive.
// Ports:
//   clock  - rising-edge clock
//   reset  - synchronous active-high reset, loads RESET_VALUE
//   load   - capture d at the edge
//   d      - load data
//   inc    - increment at the edge (ignored while load is high)
//   dec    - decrement at the edge (ignored while load/inc is high)
//   q      - current register contents
//   wrap   - the pending count would wrap (all-ones -> 0 or 0 -> all-ones)
module gp_register_cell #(
    parameter int               WIDTH       = 16,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    input  logic             inc,
    input  logic             dec,
    output logic [WIDTH-1:0] q,
    output logic             wrap
);

    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] next_s;
    logic             wrap_s;

    // Next value and wrap detection; a load masks any count in the same cycle.
    always_comb begin
        next_s = q_r;
        wrap_s = 1'b0;
        if (load) begin
            next_s = d;
        end else if (inc) begin
            next_s = q_r + {{(WIDTH-1){1'b0}}, 1'b1};
            wrap_s = (q_r == {WIDTH{1'b1}});
        end else if (dec) begin
            next_s = q_r - {{(WIDTH-1){1'b0}}, 1'b1};
            wrap_s = (q_r == {WIDTH{1'b0}});
        end else begin
            next_s = q_r;
        end
    end

    // Register storage with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            q_r <= RESET_VALUE;
        end else begin
            q_r <= next_s;
        end
    end

    assign q    = q_r;
    assign wrap = wrap_s;

endmodule

// File: rtl/gp_register_file.sv
// gp_register_file
//   DEPTH x WIDTH general-purpose register bank with one bus write port, an
//   in-place increment/decrement port, and two three-state read ports.
// Ports:
//   clock, reset    - rising-edge clock, synchronous active-high reset
//   notLoad, wrSel, in   - active-low write strobe, target, data
//   op, cntSel      - count operation (hold/inc/dec/reserved) and target
//   notOEA, selA, outA   - A read port: active-low enable, select, 3-state bus
//   notOEB, selB, outB   - B read port: active-low enable, select, 3-state bus
//   zeroA           - register[selA] == 0, regardless of notOEA
//   carry           - registered wrap flag of the last count that took effect
module gp_register_file
    import gp_regfile_pkg::*;
#(
    parameter int               WIDTH       = 16,
    parameter int               DEPTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}},
    localparam int              SELW        = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             notLoad,
    input  logic [SELW-1:0]  wrSel,
    input  logic [WIDTH-1:0] in,
    input  logic [1:0]       op,
    input  logic [SELW-1:0]  cntSel,
    input  logic             notOEA,
    input  logic [SELW-1:0]  selA,
    output logic [WIDTH-1:0] outA,
    input  logic             notOEB,
    input  logic [SELW-1:0]  selB,
    output logic [WIDTH-1:0] outB,
    output logic             zeroA,
    output logic             carry
);

    logic [DEPTH-1:0][WIDTH-1:0] q_s;
    logic [DEPTH-1:0]            wrap_s;
    logic                        inc_s;
    logic                        dec_s;
    logic                        collide_s;
    logic                        count_live_s;
    logic                        carry_r;
    logic [WIDTH-1:0]            rd_a_s;
    logic [WIDTH-1:0]            rd_b_s;

    // Decode the count operation; reserved behaves exactly like hold.
    always_comb begin
        inc_s = 1'b0;
        dec_s = 1'b0;
        case (op)
            OP_INC:           inc_s = 1'b1;
            OP_DEC:           dec_s = 1'b1;
            OP_HOLD, OP_RSVD: begin
                inc_s = 1'b0;
                dec_s = 1'b0;
            end
            default: begin
                inc_s = 1'b0;
                dec_s = 1'b0;
            end
        endcase
    end

    // A write to the counted register wins; the count (and its carry) is dropped.
    assign collide_s    = !notLoad && (wrSel == cntSel);
    assign count_live_s = (inc_s || dec_s) && !collide_s;

    for (genvar g = 0; g < DEPTH; g++) begin : g_cell
        localparam logic [SELW-1:0] IDX = SELW'(g);

        gp_register_cell #(
            .WIDTH       (WIDTH),
            .RESET_VALUE (RESET_VALUE)
        ) u_cell (
            .clock (clock),
            .reset (reset),
            .load  (!notLoad && (wrSel == IDX)),
            .d     (in),
            .inc   (inc_s && (cntSel == IDX)),
            .dec   (dec_s && (cntSel == IDX)),
            .q     (q_s[g]),
            .wrap  (wrap_s[g])
        );
    end

    // Carry follows only counts that actually change a register.
    always_ff @(posedge clock) begin
        if (reset) begin
            carry_r <= 1'b0;
        end else if (count_live_s) begin
            carry_r <= wrap_s[cntSel];
        end else begin
            carry_r <= carry_r;
        end
    end

    // Read path is purely combinational from the stored values (no bypass).
    assign rd_a_s = q_s[selA];
    assign rd_b_s = q_s[selB];
    assign outA   = notOEA ? {WIDTH{1'bz}} : rd_a_s;
    assign outB   = notOEB ? {WIDTH{1'bz}} : rd_b_s;
    assign zeroA  = (rd_a_s == {WIDTH{1'b0}});
    assign carry  = carry_r;

endmodule

// File: tb/tb_gp_register_file.sv
// tb_gp_register_file
//   Table of directed vectors, a few hand-written read-port sequences, then
//   randomized traffic compared against an array-based reference model.
module tb_gp_register_file;

    localparam int         WIDTH = 16;
    localparam int         DEPTH = 8;
    localparam int         SELW  = 3;
    localparam logic [15:0] RV   = 16'h0000;

    logic             clock;
    logic             reset;
    logic             notLoad;
    logic [SELW-1:0]  wrSel;
    logic [WIDTH-1:0] in;
    logic [1:0]       op;
    logic [SELW-1:0]  cntSel;
    logic             notOEA;
    logic [SELW-1:0]  selA;
    wire  [WIDTH-1:0] outA;
    logic             notOEB;
    logic [SELW-1:0]  selB;
    wire  [WIDTH-1:0] outB;
    wire              zeroA;
    wire              carry;

    gp_register_file #(
        .WIDTH       (WIDTH),
        .DEPTH       (DEPTH),
        .RESET_VALUE (RV)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .notLoad (notLoad),
        .wrSel   (wrSel),
        .in      (in),
        .op      (op),
        .cntSel  (cntSel),
        .notOEA  (notOEA),
        .selA    (selA),
        .outA    (outA),
        .notOEB  (notOEB),
        .selB    (selB),
        .outB    (outB),
        .zeroA   (zeroA),
        .carry   (carry)
    );

    initial clock = 1'b0;
    always #10 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    // Reference model: plain array of register values plus the carry flag.
    logic [15:0] mdl [DEPTH];
    logic        mdl_carry;

    typedef struct {
        logic        rst;
        logic        nl;
        logic [2:0]  ws;
        logic [15:0] din;
        logic [1:0]  op;
        logic [2:0]  cs;
        logic [2:0]  sa;
        logic        chk_pre;
        logic [15:0] pre_a;
        logic [15:0] exp_a;
        logic        exp_z;
        logic        exp_c;
    } vec_t;

    vec_t vecs [11];

    task automatic chk16(input string what, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", what, act, exp);
        end
    endtask

    task automatic chk1(input string what, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", what, act, exp);
        end
    endtask

    // A disabled port must not show the selected register. Two-state simulators
    // resolve an undriven bus to zero, so either z or zero is accepted; the
    // caller points the port at a nonzero register.
    task automatic chk_float(input string what, input logic [15:0] act, input logic [15:0] stored);
        checks++;
        if (!((act === {16{1'bz}}) || (act === 16'h0000)) || (act === stored)) begin
            failures++;
            $display("FAIL %s: got %h expected z (register holds %h)", what, act, stored);
        end
    endtask

    // Apply the rules for one edge to the model, using the inputs now on the pins.
    task automatic model_step();
        logic [15:0] old [DEPTH];
        bit          counting;
        old = mdl;
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mdl[i] = RV;
            mdl_carry = 1'b0;
        end else begin
            counting = (op == 2'b01 || op == 2'b10) && !(notLoad == 1'b0 && wrSel == cntSel);
            if (counting) begin
                if (op == 2'b01) begin
                    mdl_carry   = (int'(old[cntSel]) == 65535);
                    mdl[cntSel] = 16'((int'(old[cntSel]) + 1) % 65536);
                end else begin
                    mdl_carry   = (int'(old[cntSel]) == 0);
                    mdl[cntSel] = 16'((int'(old[cntSel]) + 65535) % 65536);
                end
            end
            if (notLoad == 1'b0) mdl[wrSel] = in;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clock);
        #1;
    endtask

    // Sweep both read ports over every register and compare with the model.
    task automatic check_all();
        for (int i = 0; i < DEPTH; i++) begin
            selA   = 3'(i);
            selB   = 3'(DEPTH - 1 - i);
            notOEA = 1'b0;
            notOEB = 1'b0;
            #1;
            chk16("rand_outA", outA, mdl[i]);
            chk16("rand_outB", outB, mdl[DEPTH - 1 - i]);
            chk1("rand_zeroA", zeroA, mdl[i] == 16'h0000);
        end
        chk1("rand_carry", carry, mdl_carry);
    endtask

    initial begin
        reset = 1'b0; notLoad = 1'b1; wrSel = 3'd0; in = 16'h0000;
        op = 2'b00; cntSel = 3'd0; notOEA = 1'b1; selA = 3'd0;
        notOEB = 1'b1; selB = 3'd0;

        //            rst   nl    ws    din        op     cs    sa    pre   pre_a      exp_a      z     c
        vecs[0]  = '{1'b1, 1'b1, 3'd0, 16'h0000, 2'b00, 3'd0, 3'd3, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 3'd2, 16'h1234, 2'b00, 3'd0, 3'd2, 1'b1, 16'h0000, 16'h1234, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 3'd5, 16'hFFFF, 2'b00, 3'd0, 3'd5, 1'b1, 16'h0000, 16'hFFFF, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 3'd0, 16'h0000, 2'b01, 3'd5, 3'd5, 1'b1, 16'hFFFF, 16'h0000, 1'b1, 1'b1};
        vecs[4]  = '{1'b0, 1'b1, 3'd0, 16'h0000, 2'b01, 3'd5, 3'd5, 1'b1, 16'h0000, 16'h0001, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 3'd1, 16'h0010, 2'b00, 3'd0, 3'd1, 1'b1, 16'h0000, 16'h0010, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 3'd0, 16'h0000, 2'b10, 3'd3, 3'd3, 1'b1, 16'h0000, 16'hFFFF, 1'b0, 1'b1};
        vecs[7]  = '{1'b0, 1'b0, 3'd1, 16'h00AA, 2'b10, 3'd1, 3'd1, 1'b1, 16'h0010, 16'h00AA, 1'b0, 1'b1};
        vecs[8]  = '{1'b0, 1'b1, 3'd0, 16'h0000, 2'b11, 3'd1, 3'd1, 1'b1, 16'h00AA, 16'h00AA, 1'b0, 1'b1};
        vecs[9]  = '{1'b0, 1'b1, 3'd0, 16'h0000, 2'b01, 3'd2, 3'd2, 1'b1, 16'h1234, 16'h1235, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 3'd0, 16'h5555, 2'b10, 3'd7, 3'd0, 1'b1, 16'h0000, 16'h5555, 1'b0, 1'b1};

        for (int v = 0; v < 11; v++) begin
            reset   = vecs[v].rst;
            notLoad = vecs[v].nl;
            wrSel   = vecs[v].ws;
            in      = vecs[v].din;
            op      = vecs[v].op;
            cntSel  = vecs[v].cs;
            selA    = vecs[v].sa;
            notOEA  = 1'b0;
            notOEB  = 1'b1;
            #1;
            if (vecs[v].chk_pre) chk16($sformatf("vec%0d_pre_outA", v), outA, vecs[v].pre_a);
            @(posedge clock);
            #1;
            chk16($sformatf("vec%0d_outA", v), outA, vecs[v].exp_a);
            chk1($sformatf("vec%0d_zeroA", v), zeroA, vecs[v].exp_z);
            chk1($sformatf("vec%0d_carry", v), carry, vecs[v].exp_c);
            if (v == 0) chk_float("reset_outB_disabled", outB, 16'h1111);
        end
        reset = 1'b0; notLoad = 1'b1; op = 2'b00;

        // Read ports: reg0=5555, reg3=FFFF, reg6=0000, reg7=FFFF at this point.
        notOEA = 1'b0; selA = 3'd0; notOEB = 1'b0; selB = 3'd7;
        #1;
        chk16("par_outA", outA, 16'h5555);
        chk16("par_outB", outB, 16'hFFFF);
        selB = 3'd0;
        #1;
        chk16("same_sel_outA", outA, 16'h5555);
        chk16("same_sel_outB", outB, 16'h5555);
        notOEB = 1'b1;
        #1;
        chk_float("outB_disabled", outB, 16'h5555);
        notOEA = 1'b1; selA = 3'd3;
        #1;
        chk_float("outA_disabled", outA, 16'hFFFF);
        chk1("zeroA_disabled_nonzero", zeroA, 1'b0);
        selA = 3'd6;
        #1;
        chk1("zeroA_disabled_zero", zeroA, 1'b1);

        // Reset in the same cycle as a write to reg4 and a count on reg5.
        reset = 1'b1; notLoad = 1'b0; wrSel = 3'd4; in = 16'hBEEF; op = 2'b01; cntSel = 3'd5;
        @(posedge clock);
        #1;
        reset = 1'b0; notLoad = 1'b1; op = 2'b00;
        notOEA = 1'b0; selA = 3'd4;
        #1;
        chk16("rst_wr_reg4", outA, RV);
        chk1("rst_wr_zeroA", zeroA, 1'b1);
        selA = 3'd5;
        #1;
        chk16("rst_cnt_reg5", outA, RV);
        chk1("rst_carry", carry, 1'b0);

        // Randomized traffic against the model.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_all();
        for (int n = 0; n < 200; n++) begin
            reset   = ($urandom_range(0, 39) == 0);
            notLoad = 1'($urandom_range(0, 1));
            wrSel   = 3'($urandom_range(0, 7));
            cntSel  = ($urandom_range(0, 3) == 0) ? wrSel : 3'($urandom_range(0, 7));
            op      = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0:       in = 16'hFFFF;
                1:       in = 16'h0000;
                2:       in = 16'h0001;
                default: in = 16'($urandom);
            endcase
            tick();
            check_all();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
